// File: rtl/gps_trk_pkg.sv
// Shared types and helpers for the GPS tracking correlator bank.
package gps_trk_pkg;

    // Drain FSM states: waiting for a pending snapshot, or streaming one packet.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    // Index width for n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add clamped to the symmetric-plus-one range of an acc_w-bit
    // two's complement word. The caller truncates the result to acc_w bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int acc_w);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = a + b;
        mx = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

endpackage

// File: rtl/corr_accum.sv
// One I/Q integrate-and-dump accumulator with its snapshot register.
module corr_accum
    import gps_trk_pkg::*;
#(
    parameter int P_W   = 13,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    vld,
    input  logic                    epoch,
    input  logic                    snap_we,
    input  logic signed [P_W-1:0]   pi,
    input  logic signed [P_W-1:0]   pq,
    output logic signed [ACC_W-1:0] snap_i,
    output logic signed [ACC_W-1:0] snap_q
);

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] snap_i_q, snap_i_d;
    logic signed [ACC_W-1:0] snap_q_q, snap_q_d;
    logic signed [ACC_W-1:0] sum_i, sum_q;

    // S3: saturating accumulate; an epoch restarts the sum and may load the snapshot.
    always_comb begin
        sum_i    = ACC_W'(sat_add(64'(acc_i_q), 64'(pi), ACC_W));
        sum_q    = ACC_W'(sat_add(64'(acc_q_q), 64'(pq), ACC_W));
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        snap_i_d = snap_i_q;
        snap_q_d = snap_q_q;
        if (!en) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (vld) begin
            acc_i_d = epoch ? '0 : sum_i;
            acc_q_d = epoch ? '0 : sum_q;
        end
        if (snap_we) begin
            snap_i_d = sum_i;
            snap_q_d = sum_q;
        end
    end

    // Accumulator and snapshot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            snap_i_q <= '0;
            snap_q_q <= '0;
        end else begin
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            snap_i_q <= snap_i_d;
            snap_q_q <= snap_q_d;
        end
    end

    assign snap_i = snap_i_q;
    assign snap_q = snap_q_q;

endmodule

// File: rtl/gps_corr_bank.sv
// Multi-channel integrate-and-dump correlator bank with a round-robin snapshot drain.
module gps_corr_bank
    import gps_trk_pkg::*;
#(
    parameter int  N_CH  = 2,
    parameter int  N_TAP = 3,
    parameter int  IN_W  = 4,
    parameter int  CAR_W = 8,
    parameter int  ACC_W = 24,
    localparam int CH_W  = idx_w(N_CH),
    localparam int TAP_W = idx_w(N_TAP)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_sample,
    input  logic [N_CH*N_TAP-1:0]   code,
    input  logic [N_CH*CAR_W-1:0]   car_sin,
    input  logic [N_CH*CAR_W-1:0]   car_cos,
    input  logic [N_CH-1:0]         epoch,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    ovr_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [TAP_W-1:0]        out_tap,
    output logic signed [ACC_W-1:0] out_i,
    output logic signed [ACC_W-1:0] out_q,
    output logic                    out_last,
    output logic [N_CH-1:0]         overrun
);

    localparam int W_W = IN_W + 1;
    localparam int P_W = IN_W + CAR_W + 1;

    logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic signed [W_W-1:0]    x_pos, x_neg;
    logic signed [W_W-1:0]    wiped_p1_d [N_CH][N_TAP];
    logic signed [W_W-1:0]    wiped_p1_q [N_CH][N_TAP];
    logic signed [CAR_W-1:0]  cos_p1_d [N_CH];
    logic signed [CAR_W-1:0]  cos_p1_q [N_CH];
    logic signed [CAR_W-1:0]  sin_p1_d [N_CH];
    logic signed [CAR_W-1:0]  sin_p1_q [N_CH];
    logic [N_CH-1:0]          epoch_p1_d, epoch_p1_q;
    logic signed [P_W-1:0]    pi_p2_d [N_CH][N_TAP];
    logic signed [P_W-1:0]    pi_p2_q [N_CH][N_TAP];
    logic signed [P_W-1:0]    pq_p2_d [N_CH][N_TAP];
    logic signed [P_W-1:0]    pq_p2_q [N_CH][N_TAP];
    logic [N_CH-1:0]          epoch_p2_d, epoch_p2_q;
    logic signed [ACC_W-1:0]  snap_i_w [N_CH][N_TAP];
    logic signed [ACC_W-1:0]  snap_q_w [N_CH][N_TAP];

    logic [N_CH-1:0]          dump, freeing, snap_we, ovr_set;
    logic [N_CH-1:0]          pending_q, pending_d;
    logic [N_CH-1:0]          overrun_q, overrun_d;
    logic                     last_acc;

    drain_state_e             state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d, rr_q, rr_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic                     hi_found, lo_found;
    logic [CH_W-1:0]          hi_ch, lo_ch;

    // S1: code wipe-off in IN_W+1 bits so negating the most negative sample is exact.
    always_comb begin
        vld_p1_d   = in_valid;
        epoch_p1_d = epoch;
        x_pos      = W_W'(in_sample);
        x_neg      = -x_pos;
        for (int c = 0; c < N_CH; c++) begin
            cos_p1_d[c] = car_cos[c*CAR_W +: CAR_W];
            sin_p1_d[c] = car_sin[c*CAR_W +: CAR_W];
            for (int t = 0; t < N_TAP; t++) begin
                wiped_p1_d[c][t] = code[c*N_TAP+t] ? x_pos : x_neg;
            end
        end
    end

    // S2: carrier wipe-off products at full precision.
    always_comb begin
        vld_p2_d   = vld_p1_q;
        epoch_p2_d = epoch_p1_q;
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < N_TAP; t++) begin
                pi_p2_d[c][t] = P_W'(wiped_p1_q[c][t]) * P_W'(cos_p1_q[c]);
                pq_p2_d[c][t] = P_W'(wiped_p1_q[c][t]) * P_W'(sin_p1_q[c]);
            end
        end
    end

    // Pipeline data registers advance only with their stage valid.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            wiped_p1_q <= wiped_p1_d;
            cos_p1_q   <= cos_p1_d;
            sin_p1_q   <= sin_p1_d;
            epoch_p1_q <= epoch_p1_d;
        end
        if (vld_p1_q) begin
            pi_p2_q    <= pi_p2_d;
            pq_p2_q    <= pq_p2_d;
            epoch_p2_q <= epoch_p2_d;
        end
    end

    // S3: per-tap accumulators and snapshot registers.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        for (genvar t = 0; t < N_TAP; t++) begin : g_tap
            corr_accum #(
                .P_W   (P_W),
                .ACC_W (ACC_W)
            ) u_acc (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (ch_en[c]),
                .vld     (vld_p2_q),
                .epoch   (epoch_p2_q[c]),
                .snap_we (snap_we[c]),
                .pi      (pi_p2_q[c][t]),
                .pq      (pq_p2_q[c][t]),
                .snap_i  (snap_i_w[c][t]),
                .snap_q  (snap_q_w[c][t])
            );
        end
    end

    // Output beat is a pure mux of drain state and the held snapshot, so it stays stable under backpressure.
    always_comb begin
        out_valid = (state_q == SEND);
        out_last  = out_valid && (tap_q == TAP_W'(N_TAP - 1));
        out_ch    = ch_q;
        out_tap   = tap_q;
        out_i     = snap_i_w[ch_q][tap_q];
        out_q     = snap_q_w[ch_q][tap_q];
        overrun   = overrun_q;
    end

    // Dump arbitration: a snapshot may load unless the previous one is still waiting, except when it leaves this cycle.
    always_comb begin
        last_acc = out_last && out_ready;
        dump     = '0;
        freeing  = '0;
        snap_we  = '0;
        ovr_set  = '0;
        for (int c = 0; c < N_CH; c++) begin
            dump[c]    = vld_p2_q && ch_en[c] && epoch_p2_q[c];
            freeing[c] = last_acc && (ch_q == CH_W'(c));
            snap_we[c] = dump[c] && !(pending_q[c] && !freeing[c]);
            ovr_set[c] = dump[c] && pending_q[c] && !freeing[c];
        end
        pending_d = (pending_q & ~freeing) | snap_we;
        overrun_d = (overrun_q & ~{N_CH{ovr_clr}}) | ovr_set;
    end

    // Drain FSM: round-robin grant from rr_q, then stream taps 0..N_TAP-1.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tap_d    = tap_q;
        rr_d     = rr_q;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                lo_found = 1'b1;
                lo_ch    = CH_W'(c);
                if (CH_W'(c) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_ch    = CH_W'(c);
                end
            end
        end
        case (state_q)
            IDLE: begin
                if (lo_found) begin
                    ch_d    = hi_found ? hi_ch : lo_ch;
                    tap_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (tap_q == TAP_W'(N_TAP - 1)) begin
                        state_d = IDLE;
                        rr_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : CH_W'(ch_q + 1'b1);
                    end else begin
                        tap_d = TAP_W'(tap_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: valids, pending/overrun flags and drain state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            pending_q <= '0;
            overrun_q <= '0;
            state_q   <= IDLE;
            ch_q      <= '0;
            tap_q     <= '0;
            rr_q      <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            tap_q     <= tap_d;
            rr_q      <= rr_d;
        end
    end

endmodule

// File: tb/tb_gps_corr_bank.sv
// Directed bench for gps_corr_bank: main instance at ACC_W=24, second at ACC_W=12 for saturation.
module tb_gps_corr_bank;

    localparam int N_CH  = 2;
    localparam int N_TAP = 3;
    localparam int IN_W  = 4;
    localparam int CAR_W = 8;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              in_valid  = 1'b0;
    logic signed [3:0] in_sample = '0;
    logic [5:0]        code      = '0;
    logic [15:0]       car_sin   = '0;
    logic [15:0]       car_cos   = '0;
    logic [1:0]        epoch     = '0;
    logic [1:0]        ch_en     = '0;
    logic              ovr_clr   = 1'b0;
    logic              out_ready = 1'b1;

    logic               out_valid, out_last;
    logic [0:0]         out_ch;
    logic [1:0]         out_tap;
    logic signed [23:0] out_i, out_q;
    logic [1:0]         overrun;

    logic               s_out_valid, s_out_last;
    logic [0:0]         s_out_ch;
    logic [1:0]         s_out_tap;
    logic signed [11:0] s_out_i, s_out_q;
    logic [1:0]         s_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gps_corr_bank #(.N_CH(N_CH), .N_TAP(N_TAP), .IN_W(IN_W), .CAR_W(CAR_W), .ACC_W(24)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sample(in_sample),
        .code(code), .car_sin(car_sin), .car_cos(car_cos), .epoch(epoch), .ch_en(ch_en),
        .ovr_clr(ovr_clr), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_tap(out_tap), .out_i(out_i), .out_q(out_q), .out_last(out_last), .overrun(overrun)
    );

    gps_corr_bank #(.N_CH(N_CH), .N_TAP(N_TAP), .IN_W(IN_W), .CAR_W(CAR_W), .ACC_W(12)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sample(in_sample),
        .code(code), .car_sin(car_sin), .car_cos(car_cos), .epoch(epoch), .ch_en(ch_en),
        .ovr_clr(ovr_clr), .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch),
        .out_tap(s_out_tap), .out_i(s_out_i), .out_q(s_out_q), .out_last(s_out_last), .overrun(s_overrun)
    );

    task automatic set_ch(input int c, input int cosv, input int sinv);
        car_cos[c*8 +: 8] = cosv[7:0];
        car_sin[c*8 +: 8] = sinv[7:0];
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
    endtask

    // n valid samples of value x, epoch mask ep on the last one.
    task automatic send_period(input int n, input int x, input logic [1:0] ep);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_sample = x[3:0];
            epoch     = (i == n - 1) ? ep : 2'b00;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        epoch    = 2'b00;
    endtask

    // Waits for out_valid (checking the wait length when exp_wait >= 0) and checks a full packet at out_ready=1.
    task automatic collect(input int exp_wait, input int exp_ch,
                           input int i0, input int i1, input int i2,
                           input int q0, input int q1, input int q2);
        int ei[3];
        int eq[3];
        int waits;
        ei[0] = i0; ei[1] = i1; ei[2] = i2;
        eq[0] = q0; eq[1] = q1; eq[2] = q2;
        waits = 0;
        while (out_valid !== 1'b1 && waits < 30) begin
            @(posedge clk);
            #1;
            waits++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pkt_timeout ch%0d: out_valid=%b after %0d cycles, required 1", exp_ch, out_valid, waits);
            return;
        end
        if (exp_wait >= 0) begin
            checks++;
            if (waits != exp_wait) begin
                errors++;
                $display("FAIL pkt_latency ch%0d: waited %0d cycles, required %0d", exp_ch, waits, exp_wait);
            end
        end
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 1'(exp_ch) || out_tap !== 2'(t) || out_last !== (t == 2)) begin
                errors++;
                $display("FAIL beat_pos ch%0d tap%0d: valid=%b ch=%0d tap=%0d last=%b, required 1/%0d/%0d/%b",
                         exp_ch, t, out_valid, out_ch, out_tap, out_last, exp_ch, t, (t == 2));
            end
            checks++;
            if (out_i !== ei[t] || out_q !== eq[t]) begin
                errors++;
                $display("FAIL beat_data ch%0d tap%0d: i=%0d q=%0d, required i=%0d q=%0d",
                         exp_ch, t, out_i, out_q, ei[t], eq[t]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycles(3);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_ch !== 1'b0 || out_tap !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b last=%b ch=%0d tap=%0d, required all 0", out_valid, out_last, out_ch, out_tap);
        end
        checks++;
        if (out_i !== 24'sd0 || out_q !== 24'sd0) begin
            errors++;
            $display("FAIL reset_data: i=%0d q=%0d, required 0/0", out_i, out_q);
        end
        checks++;
        if (overrun !== 2'b00 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: overrun=%b s_valid=%b, required 00/0", overrun, s_out_valid);
        end
        reset_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_basic();
        ch_en = 2'b01;
        code  = 6'b000_111;
        set_ch(0, 100, 0);
        send_period(10, 3, 2'b01);
        collect(3, 0, 3000, 3000, 3000, 0, 0, 0);
        checks++;
        if (overrun !== 2'b00) begin
            errors++;
            $display("FAIL basic_overrun: overrun=%b, required 00", overrun);
        end
    endtask

    task automatic test_code_neg();
        code = 6'b000_101;
        set_ch(0, 100, 0);
        send_period(10, 3, 2'b01);
        collect(3, 0, 3000, -3000, 3000, 0, 0, 0);
        code = 6'b000_000;
        set_ch(0, 127, 10);
        send_period(2, -8, 2'b01);
        collect(3, 0, 2032, 2032, 2032, 160, 160, 160);
    endtask

    task automatic test_saturation();
        int x, es, em, waits;
        ch_en = 2'b01;
        code  = 6'b000_111;
        set_ch(0, 127, 0);
        for (int pass = 0; pass < 2; pass++) begin
            x  = (pass == 0) ? 7 : -7;
            es = (pass == 0) ? 2047 : -2048;
            em = (pass == 0) ? 2667 : -2667;
            send_period(3, x, 2'b01);
            waits = 0;
            while (s_out_valid !== 1'b1 && waits < 30) begin
                @(posedge clk);
                #1;
                waits++;
            end
            checks++;
            if (s_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sat_timeout pass%0d: s_out_valid=%b, required 1", pass, s_out_valid);
            end else begin
                checks++;
                if (out_i !== em) begin
                    errors++;
                    $display("FAIL sat_wide pass%0d: i=%0d, required %0d", pass, out_i, em);
                end
                for (int t = 0; t < 3; t++) begin
                    checks++;
                    if (s_out_i !== es || s_out_q !== 12'sd0 || s_out_tap !== 2'(t)) begin
                        errors++;
                        $display("FAIL sat_beat pass%0d tap%0d: i=%0d q=%0d tap=%0d, required i=%0d q=0 tap=%0d",
                                 pass, t, s_out_i, s_out_q, s_out_tap, es, t);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic test_both_channels();
        do_reset();
        ch_en = 2'b11;
        code  = 6'b010_111;
        set_ch(0, 100, 0);
        set_ch(1, -20, 5);
        send_period(4, 2, 2'b11);
        collect(3, 0, 800, 800, 800, 0, 0, 0);
        collect(1, 1, 160, -160, 160, -40, 40, -40);
        checks++;
        if (overrun !== 2'b00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_after: overrun=%b valid=%b, required 00/0", overrun, out_valid);
        end
    endtask

    task automatic test_overrun();
        ch_en     = 2'b01;
        code      = 6'b000_111;
        set_ch(0, 10, 0);
        out_ready = 1'b0;
        send_period(2, 1, 2'b01);
        cycles(4);
        checks++;
        if (out_valid !== 1'b1 || out_i !== 24'sd20 || overrun !== 2'b00) begin
            errors++;
            $display("FAIL ovr_first: valid=%b i=%0d overrun=%b, required 1/20/00", out_valid, out_i, overrun);
        end
        send_period(2, 5, 2'b01);
        cycles(3);
        checks++;
        if (overrun !== 2'b01) begin
            errors++;
            $display("FAIL ovr_flag: overrun=%b, required 01", overrun);
        end
        checks++;
        if (out_valid !== 1'b1 || out_tap !== 2'd0 || out_i !== 24'sd20) begin
            errors++;
            $display("FAIL ovr_hold: valid=%b tap=%0d i=%0d, required 1/0/20", out_valid, out_tap, out_i);
        end
        out_ready = 1'b1;
        collect(0, 0, 20, 20, 20, 0, 0, 0);
        cycles(3);
        checks++;
        if (overrun !== 2'b01 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky: overrun=%b valid=%b, required 01/0", overrun, out_valid);
        end
        ovr_clr = 1'b1;
        cycles(1);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 2'b00) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b, required 00", overrun);
        end
    endtask

    task automatic test_reset_midpacket();
        int waits;
        ch_en = 2'b01;
        code  = 6'b000_111;
        set_ch(0, 100, 0);
        send_period(10, 3, 2'b01);
        waits = 0;
        while (out_valid !== 1'b1 && waits < 30) begin
            @(posedge clk);
            #1;
            waits++;
        end
        cycles(1);
        checks++;
        if (out_valid !== 1'b1 || out_tap !== 2'd1) begin
            errors++;
            $display("FAIL mid_beat1: valid=%b tap=%0d, required 1/1", out_valid, out_tap);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_tap !== 2'd0 || out_i !== 24'sd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b tap=%0d i=%0d, required 0/0/0", out_valid, out_tap, out_i);
        end
        cycles(2);
        reset_n = 1'b1;
        cycles(6);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_replay: valid=%b, required 0", out_valid);
        end
        send_period(10, 3, 2'b01);
        collect(3, 0, 3000, 3000, 3000, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_code_neg();
        test_saturation();
        test_both_channels();
        test_overrun();
        test_reset_midpacket();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gps_corr_bank.md
# gps_corr_bank

Parametrised multi-channel integrate-and-dump correlator bank for the GPS tracking front end. Each channel wipes a real IF sample stream with N_TAP code replicas (early…late) and the channel's carrier sin/cos, accumulates I/Q per tap over one code period, and snapshots the sums on the channel's epoch strobe. Snapshots are drained as a ready/valid beat stream to the DLL/Costas discriminator logic, which replaces the per-tap combinational xor chains used today.

## Interface
- N_CH, 2: number of tracking channels (1..8)
- N_TAP, 3: correlator taps per channel (odd, 1..7; centre tap = punctual)
- IN_W, 4: signed IF sample width
- CAR_W, 8: signed carrier sin/cos width
- ACC_W, 24: signed accumulator/output width (≥ IN_W+CAR_W+1)

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample qualifier
- in_sample  in  IN_W  signed IF sample, shared by all channels
- code  in  N_CH*N_TAP  replica chip per channel/tap; 1 = +1, 0 = −1; index c*N_TAP+t
- car_sin, car_cos  in  N_CH*CAR_W  per-channel signed carrier
- epoch  in  N_CH  last sample of code period, sampled with in_valid
- ch_en  in  N_CH  channel enable
- ovr_clr  in  1  pulse, clears all overrun flags
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_ch  out  $clog2(N_CH) (min 1)  channel of beat
- out_tap  out  $clog2(N_TAP) (min 1)  tap of beat, 0 = earliest
- out_i, out_q  out  ACC_W  signed tap sums
- out_last  out  1  last tap of packet
- overrun  out  N_CH  sticky per-channel overrun

## Operation
- Pipeline advances only on valid; valid, code, carrier and epoch travel with the sample.
- S1: wiped = code ? x : −x, computed in IN_W+1 bits (−(−2^(IN_W−1)) is exact).
- S2: pi = wiped·cos, pq = wiped·sin, IN_W+CAR_W+1 bits.
- S3: acc += p, saturating to ±(2^(ACC_W−1)−1)/−2^(ACC_W−1); no wrap. Epoch sample is included; then snapshot ← acc+p (saturated), acc ← 0, pending[c] ← 1.
- ch_en[c]=0: acc held 0, epochs ignored; deasserting mid-period discards the partial sum. A pending snapshot is still drained.
- Dump while pending[c]=1: new sums discarded, snapshot untouched, overrun[c] ← 1. Exception: dump in the same cycle as the accepted out_last of channel c is accepted (no overrun).
- ovr_clr and a new overrun in the same cycle: overrun stays 1.
- Drain FSM: IDLE → SEND when any pending; round-robin grant starting after last served channel. SEND emits taps 0..N_TAP−1, one per out_valid&out_ready; out_last on tap N_TAP−1; on its acceptance pending cleared, → IDLE.
- Output beat fields stable while out_valid=1 and out_ready=0.

## Timing
- Sample with epoch accepted at edge k: S1 at k, S2 at k+1, snapshot/pending at k+2, FSM grant at k+3; out_valid high in the cycle after k+3. Latency 4 cycles at out_ready=1.
- Packet = N_TAP beats, back-to-back at full ready; one IDLE cycle between packets.
- Reset (async assert, sync deassert assumed externally): out_valid=0, out_ch=0, out_tap=0, out_i=out_q=0, out_last=0, overrun=0; accumulators, snapshots, pending, pipeline valids, RR pointer cleared. Reset mid-packet aborts it; nothing replayed.

## Structure
- Package gps_trk_pkg: drain FSM state enum (IDLE, SEND), saturation function sat_add(ACC_W), tap/channel index widths.
- Sub-module corr_accum: one I/Q saturating accumulator with snapshot register, instantiated N_CH·N_TAP times via generate; bank top holds S1/S2, pending/overrun and drain FSM.

## Test plan
(N_CH=2, N_TAP=3, IN_W=4, CAR_W=8, ACC_W=24 unless stated)
- Ch0, x=3, cos=100, sin=0, all code 1, 10 samples, epoch on 10th → 3 beats ch0, out_i=3000, out_q=0, out_last on tap 2, out_valid 4 cycles after epoch sample.
- Same, tap1 code 0 → tap1 out_i=−3000; x=−8 code 0 cos=127, 2 samples → out_i=2032 (negation exact).
- ACC_W=12, x=7, cos=127, code 1, 3 samples → out_i=2047 (saturated); x=−7 → −2048.
- Both channels epoch same cycle → ch0 packet then ch1 packet, 7 cycles total; no overrun.
- out_ready=0 while ch0 pending, second ch0 epoch → overrun[0]=1, first snapshot delivered intact; ovr_clr → overrun[0]=0.
- reset_n low during beat 1 → out_valid=0 immediately; after release, next 10-sample period returns out_i=3000 (no residue).
